// File: rtl/instr_encoder.sv
// ---------------------------------------------------------------------------
// instr_encoder
//   Accepts symbolic instruction requests (mnemonic plus operand fields),
//   encodes each one into a 32-bit MIPS-style instruction word and writes the
//   words to consecutive instruction-memory addresses through a 4-entry FIFO.
//   A session is opened by a start pulse and closed by a request carrying
//   in_last; the block reports done once every buffered word has been written.
//
// Ports
//   clk, rst          clock and synchronous active-high reset
//   start, base_addr  open a session at word address base_addr
//   in_valid/in_ready request handshake
//   in_code           mnemonic (0..11 legal, 12..15 illegal)
//   in_rs/rt/rd/sa    5-bit register / shift-amount fields
//   in_imm, in_target 16-bit immediate, 26-bit jump target
//   in_last           marks the final request of the session
//   wr_valid/wr_ready instruction-memory write handshake
//   wr_addr, wr_data  write address and data (FIFO head)
//   busy, done        session running / session complete
//   err_illegal       sticky: an illegal mnemonic was dropped this session
//   word_count        words written this session, saturating at 2047
// ---------------------------------------------------------------------------
module instr_encoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [9:0]  base_addr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_code,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_sa,
  input  logic [15:0] in_imm,
  input  logic [25:0] in_target,
  input  logic        in_last,
  output logic        wr_valid,
  input  logic        wr_ready,
  output logic [9:0]  wr_addr,
  output logic [31:0] wr_data,
  output logic        busy,
  output logic        done,
  output logic        err_illegal,
  output logic [10:0] word_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [10:0] WC_MAX = 11'd2047;

  // Returns {legal, word}. Illegal codes return legal = 0 and a zero word.
  function automatic logic [32:0] encode(
    input logic [3:0]  code,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [4:0]  rd,
    input logic [4:0]  sa,
    input logic [15:0] imm,
    input logic [25:0] tgt
  );
    logic [31:0] w;
    logic        ok;
    w  = 32'd0;
    ok = 1'b1;
    case (code)
      4'd0:    w = {6'b000000, rs, rt, rd, 5'b00000, 6'b100000}; // ADD
      4'd1:    w = {6'b000000, rs, rt, rd, 5'b00000, 6'b100010}; // SUB
      4'd2:    w = {6'b000000, rs, rt, rd, 5'b00000, 6'b100100}; // AND
      4'd3:    w = {6'b000000, rs, rt, rd, 5'b00000, 6'b100101}; // OR
      4'd4:    w = {6'b000000, rs, rt, rd, 5'b00000, 6'b100110}; // XOR
      4'd5:    w = {6'b000000, 5'b00000, rt, rd, sa, 6'b000000}; // SLL
      4'd6:    w = {6'b000000, rs, rt, rd, 5'b00000, 6'b001010}; // MOVZ
      4'd7:    w = {6'b100011, rs, rt, imm};                     // LW
      4'd8:    w = {6'b101011, rs, rt, imm};                     // SW
      4'd9:    w = {6'b000010, tgt};                             // J
      4'd10:   w = {6'b111110, rs, rt, rd, 5'b00000, 6'b000000}; // CMP
      4'd11:   w = {6'b111111, rs, rt, imm};                     // BBT
      default: ok = 1'b0;
    endcase
    return {ok, w};
  endfunction

  state_t      state_q, state_d;
  logic [31:0] fifo_q [4];
  logic [1:0]  wptr_q, wptr_d;
  logic [1:0]  rptr_q, rptr_d;
  logic [2:0]  count_q, count_d;
  logic [9:0]  addr_q, addr_d;
  logic [10:0] wc_q, wc_d;
  logic        err_q, err_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [32:0] enc;
  logic        legal;
  logic        accept;
  logic        push;
  logic        pop;

  // Stage: request acceptance and encoding
  assign enc      = encode(in_code, in_rs, in_rt, in_rd, in_sa, in_imm, in_target);
  assign legal    = enc[32];
  // in_ready looks only at the registered count, so a full FIFO stays
  // closed even in a cycle where the head is being written out.
  assign in_ready = (state_q == S_RUN) && (count_q != 3'd4);
  assign accept   = in_valid && in_ready;
  assign push     = accept && legal;
  assign pop      = wr_valid && wr_ready;

  // Stage: FIFO head to instruction-memory write port
  assign wr_valid    = (count_q != 3'd0);
  assign wr_data     = wr_valid ? fifo_q[rptr_q] : 32'd0;
  assign wr_addr     = addr_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err_illegal = err_q;
  assign word_count  = wc_q;

  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    addr_d  = addr_q;
    wc_d    = wc_q;
    err_d   = err_q;

    if (push) wptr_d = wptr_q + 2'd1;

    if (pop) begin
      rptr_d = rptr_q + 2'd1;
      addr_d = addr_q + 10'd1;               // 10-bit wrap: 1023 -> 0
      if (wc_q != WC_MAX) wc_d = wc_q + 11'd1;
    end

    if (accept && !legal) err_d = 1'b1;

    count_d = count_q + {2'b00, push} - {2'b00, pop};

    case (state_q)
      S_IDLE, S_DONE: begin
        // FIFO is empty here, so start cannot collide with a pop.
        if (start) begin
          state_d = S_RUN;
          addr_d  = base_addr;
          wc_d    = 11'd0;
          err_d   = 1'b0;
        end
      end
      S_RUN: begin
        if (accept && in_last) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        // Nothing can be pushed in DRAIN, so an empty FIFO means no write
        // is pending.
        if (count_q == 3'd0) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
    done_d = (state_d == S_DONE);
  end

  // Stage: control state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      wptr_q  <= 2'd0;
      rptr_q  <= 2'd0;
      count_q <= 3'd0;
      addr_q  <= 10'd0;
      wc_q    <= 11'd0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      addr_q  <= addr_d;
      wc_q    <= wc_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Stage: FIFO storage (data only; emptiness is tracked by count_q)
  always_ff @(posedge clk) begin
    if (push && !rst) fifo_q[wptr_q] <= enc[31:0];
  end

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [9:0]  base_addr;
  logic        in_valid, in_ready;
  logic [3:0]  in_code;
  logic [4:0]  in_rs, in_rt, in_rd, in_sa;
  logic [15:0] in_imm;
  logic [25:0] in_target;
  logic        in_last;
  logic        wr_valid, wr_ready;
  logic [9:0]  wr_addr;
  logic [31:0] wr_data;
  logic        busy, done, err_illegal;
  logic [10:0] word_count;

  instr_encoder dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_sa(in_sa),
    .in_imm(in_imm), .in_target(in_target), .in_last(in_last),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy), .done(done),
    .err_illegal(err_illegal), .word_count(word_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef enum {M_IDLE, M_RUN, M_DRAIN, M_DONE} mst_t;
  mst_t        mst;
  logic [31:0] q[$];
  int          maddr, mwc;
  bit          merr;
  bit          rnd_rdy, last_acc;
  logic [31:0] log_d[$];
  int          log_a[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference encoding from the instruction-format table, by field weights.
  function automatic logic [31:0] ref_enc(input int c, input int rs, input int rt,
                                          input int rd, input int sa, input int imm,
                                          input int tgt);
    longint r, f, op;
    r = longint'(rs) * 2097152 + longint'(rt) * 65536 + longint'(rd) * 2048;
    case (c)
      0: f = 32; 1: f = 34; 2: f = 36; 3: f = 37; 4: f = 38; 6: f = 10;
      default: f = 0;
    endcase
    case (c)
      0, 1, 2, 3, 4, 6: op = r + f;
      5:  op = longint'(rt) * 65536 + longint'(rd) * 2048 + longint'(sa) * 64;
      7:  op = 35 * 67108864 + longint'(rs) * 2097152 + longint'(rt) * 65536 + imm;
      8:  op = 43 * 67108864 + longint'(rs) * 2097152 + longint'(rt) * 65536 + imm;
      9:  op = 2 * 67108864 + longint'(tgt);
      10: op = 62 * 67108864 + r;
      11: op = 63 * 67108864 + longint'(rs) * 2097152 + longint'(rt) * 65536 + imm;
      default: op = 0;
    endcase
    return op[31:0];
  endfunction

  // One clock: check outputs against the model, advance the model by what
  // the coming edge will do, then return 1 time unit after the edge.
  task automatic tick();
    int sz;
    bit wr, acc;
    @(negedge clk);
    sz = q.size();
    chk("in_ready", in_ready, (mst == M_RUN) && (sz < 4));
    chk("wr_valid", wr_valid, sz != 0);
    chk("busy", busy, (mst == M_RUN) || (mst == M_DRAIN));
    chk("done", done, mst == M_DONE);
    chk("err_illegal", err_illegal, merr);
    chk("word_count", word_count, mwc);
    chk("wr_addr", wr_addr, maddr);
    if (sz != 0) chk("wr_data", wr_data, q[0]);
    wr  = wr_valid && wr_ready;
    acc = in_valid && in_ready;
    last_acc = acc && !rst;
    if (rst) begin
      mst = M_IDLE; q.delete(); maddr = 0; mwc = 0; merr = 0;
    end else begin
      if (wr) begin
        if (sz == 0) chk("spurious_write", wr, 0);
        else begin
          log_d.push_back(q.pop_front());
          log_a.push_back(maddr);
          maddr = (maddr + 1) % 1024;
          if (mwc < 2047) mwc++;
        end
      end
      if (acc) begin
        if (in_code < 12)
          q.push_back(ref_enc(in_code, in_rs, in_rt, in_rd, in_sa, in_imm, in_target));
        else merr = 1;
      end
      case (mst)
        M_IDLE, M_DONE: if (start) begin
          mst = M_RUN; maddr = base_addr; mwc = 0; merr = 0;
        end
        M_RUN:   if (acc && in_last) mst = M_DRAIN;
        M_DRAIN: if (sz == 0) mst = M_DONE;
        default: ;
      endcase
    end
    @(posedge clk);
    #1;
    if (rnd_rdy) wr_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic present(input int c, input int rs, input int rt, input int rd,
                         input int sa, input int imm, input int tgt, input bit last);
    in_valid = 1'b1; in_code = 4'(c); in_rs = 5'(rs); in_rt = 5'(rt); in_rd = 5'(rd);
    in_sa = 5'(sa); in_imm = 16'(imm); in_target = 26'(tgt); in_last = last;
  endtask

  task automatic wait_acc();
    int n = 0;
    do begin tick(); n++; end while (!last_acc && n < 500);
    if (!last_acc) chk("accept_timeout", last_acc, 1);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic send(input int c, input int rs, input int rt, input int rd,
                      input int sa, input int imm, input int tgt, input bit last);
    present(c, rs, rt, rd, sa, imm, tgt, last);
    wait_acc();
  endtask

  task automatic do_start(input logic [9:0] b);
    start = 1'b1; base_addr = b;
    tick();
    start = 1'b0;
    log_d.delete(); log_a.delete();
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 300) begin tick(); n++; end
    chk("done_reached", done, 1);
  endtask

  task automatic reset_check(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_wr_valid"}, wr_valid, 0);
    chk({tag, "_wr_addr"}, wr_addr, 0);
    chk({tag, "_wr_data"}, wr_data, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err_illegal, 0);
    chk({tag, "_wcount"}, word_count, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; base_addr = '0; in_valid = 1'b0; in_code = '0;
    in_rs = '0; in_rt = '0; in_rd = '0; in_sa = '0; in_imm = '0; in_target = '0;
    in_last = 1'b0; wr_ready = 1'b1; rnd_rdy = 0;
    mst = M_IDLE; maddr = 0; mwc = 0; merr = 0;
    repeat (2) @(posedge clk);
    #1;
    reset_check("por");
    rst = 1'b0;
    tick();

    // Single ADD, latency 1
    do_start(10'h010);
    send(0, 1, 2, 3, 0, 0, 0, 1);
    chk("t27_vld", wr_valid, 1);
    chk("t27_addr", wr_addr, 10'h010);
    chk("t27_data", wr_data, 32'h00221820);
    wait_done();

    // LW, SW, J
    do_start(10'h020);
    send(7, 4, 5, 0, 0, 16'h0008, 0, 0);
    send(8, 4, 5, 0, 0, 16'h0008, 0, 0);
    send(9, 0, 0, 0, 0, 0, 26'h0000040, 1);
    wait_done();
    chk("t28_n", log_d.size(), 3);
    chk("t28_d0", log_d[0], 32'h8C850008);
    chk("t28_d1", log_d[1], 32'hAC850008);
    chk("t28_d2", log_d[2], 32'h08000040);
    chk("t28_a2", log_a[2], 32'h022);
    chk("t28_wc", word_count, 3);

    // Backpressure: FIFO fills at 4, head held
    do_start(10'h100);
    wr_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(0, 1, 2, 3 + i, 0, 0, 0, 0);
    present(0, 1, 2, 7, 0, 0, 0, 1);
    repeat (3) begin
      tick();
      chk("t29_rdy", in_ready, 0);
      chk("t29_hold", wr_data, 32'h00221820);
    end
    wr_ready = 1'b1;
    wait_acc();
    wait_done();
    chk("t29_n", log_d.size(), 5);
    for (int i = 0; i < 5; i++) begin
      chk("t29_d", log_d[i], 32'h00220020 + 32'((3 + i) * 2048));
      chk("t29_a", log_a[i], 32'h100 + 32'(i));
    end

    // Illegal code dropped
    do_start(10'h040);
    send(1, 1, 2, 3, 0, 0, 0, 0);
    send(13, 1, 2, 3, 0, 0, 0, 0);
    send(1, 1, 2, 3, 0, 0, 0, 1);
    wait_done();
    chk("t30_err", err_illegal, 1);
    chk("t30_wc", word_count, 2);
    chk("t30_d1", log_d[1], 32'h00221822);
    chk("t30_a1", log_a[1], 32'h041);

    // Address wrap
    do_start(10'h3FF);
    send(5, 0, 2, 3, 4, 0, 0, 0);
    send(5, 0, 2, 3, 4, 0, 0, 1);
    wait_done();
    chk("t31_d0", log_d[0], 32'h00021900);
    chk("t31_a0", log_a[0], 32'h3FF);
    chk("t31_a1", log_a[1], 32'h000);

    // Reset with 3 words buffered
    do_start(10'h0AA);
    wr_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(2, i, i + 1, i + 2, 0, 0, 0, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    reset_check("t32");
    wr_ready = 1'b1;
    repeat (5) tick();

    // word_count saturation
    do_start(10'h200);
    for (int i = 0; i < 2050; i++) send(3, i % 32, 7, 9, 0, 0, 0, i == 2049);
    wait_done();
    chk("sat_wc", word_count, 2047);

    // Randomized sessions
    rnd_rdy = 1;
    for (int s = 0; s < 10; s++) begin
      do_start(($urandom_range(0, 3) == 0) ? 10'h3FD : 10'($urandom));
      begin
        int n;
        n = $urandom_range(5, 30);
        for (int i = 0; i < n; i++) begin
          if ($urandom_range(0, 3) == 0) tick();
          start = ($urandom_range(0, 9) == 0);
          base_addr = 10'($urandom);
          send($urandom_range(0, 15), $urandom_range(0, 31), $urandom_range(0, 31),
               $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 65535),
               $urandom_range(0, 67108863), i == n - 1);
          start = 1'b0;
        end
      end
      wait_done();
    end
    rnd_rdy = 0;
    wr_ready = 1'b1;
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
